// File: rtl/fft_stream_pkg.sv
// Shared defaults and sample types for the FFT streaming shell.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_stream_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_OUTPUT_WIDTH = 16;
    localparam int DEF_FRAME_LEN    = 256;

    // Sample index width for the default frame length.
    localparam int IDX_W = $clog2(DEF_FRAME_LEN);

    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] re;
        logic signed [DEF_DATA_WIDTH-1:0] im;
    } cplx_in_t;

    typedef struct packed {
        logic signed [DEF_OUTPUT_WIDTH-1:0] re;
        logic signed [DEF_OUTPUT_WIDTH-1:0] im;
    } cplx_out_t;

endpackage

// File: rtl/fft_stream_framer_fifo.sv
// Generic count-based ready/valid FIFO (also used as a 2-entry skid buffer).
// Latency: 1 cycle push-to-out_valid, no fall-through; out_data is 0 while empty.
// Backpressure: in_ready = (count < DEPTH) from the count register; a pop frees a slot next cycle.
// Ports: clk, rst_n; in_valid/in_ready/in_data (write side); out_valid/out_ready/out_data (read side).
module stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Gate the read port so nothing stale leaks out while empty (e.g. after a reset).
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: it is only visible through out_data, which is gated by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/fft_stream_framer.sv
// Frame-aware shell between host ready/valid streams and the FFT core handshakes.
// Latency: 1 cycle host->core (skid), 1 cycle core->m_axis (FIFO); no fall-through.
// Backpressure: s_axis_ready = skid not full; core_out_ready = output FIFO not full.
// Ports: s_axis_* host input stream; core_in_* to core; core_out_* from core; m_axis_* output
//        stream with regenerated last; clear_err, sticky err_* flags, in/out frame counters.
module fft_stream_framer
    import fft_stream_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
    parameter int FRAME_LEN      = DEF_FRAME_LEN,
    parameter int OUT_FIFO_DEPTH = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_axis_valid,
    output logic                      s_axis_ready,
    input  logic [2*DATA_WIDTH-1:0]   s_axis_data,
    input  logic                      s_axis_last,
    output logic                      core_in_valid,
    input  logic                      core_in_ready,
    output logic [2*DATA_WIDTH-1:0]   core_in_data,
    input  logic                      core_out_valid,
    output logic                      core_out_ready,
    input  logic [2*OUTPUT_WIDTH-1:0] core_out_data,
    output logic                      m_axis_valid,
    input  logic                      m_axis_ready,
    output logic [2*OUTPUT_WIDTH-1:0] m_axis_data,
    output logic                      m_axis_last,
    input  logic                      clear_err,
    output logic                      err_early_last,
    output logic                      err_missing_last,
    output logic [CNT_WIDTH-1:0]      in_frame_cnt,
    output logic [CNT_WIDTH-1:0]      out_frame_cnt
);

    localparam int IDX_BITS = $clog2(FRAME_LEN);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FRAME_LEN - 1);

    // ---------------- input side ----------------
    stream_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (2)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_axis_valid),
        .in_ready  (s_axis_ready),
        .in_data   (s_axis_data),
        .out_valid (core_in_valid),
        .out_ready (core_in_ready),
        .out_data  (core_in_data)
    );

    logic [IDX_BITS-1:0] in_idx;
    logic                host_accept;
    logic                at_last_in;
    logic                early_evt;
    logic                missing_evt;

    assign host_accept = s_axis_valid && s_axis_ready;
    assign at_last_in  = (in_idx == LAST_IDX);
    assign early_evt   = host_accept && s_axis_last && !at_last_in;
    assign missing_evt = host_accept && !s_axis_last && at_last_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_idx           <= '0;
            in_frame_cnt     <= '0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
        end else begin
            if (host_accept) begin
                // Any last marker resynchronises the index, even an early one.
                if (s_axis_last || at_last_in) in_idx <= '0;
                else                           in_idx <= in_idx + 1'b1;
                // A full frame's worth of samples counts as a frame, marker or not.
                if (at_last_in) in_frame_cnt <= in_frame_cnt + 1'b1;
            end
            // A new error event in the same cycle as clear_err keeps the flag set.
            err_early_last   <= early_evt   | (err_early_last   & ~clear_err);
            err_missing_last <= missing_evt | (err_missing_last & ~clear_err);
        end
    end

    // ---------------- output side ----------------
    stream_fifo #(
        .WIDTH (2*OUTPUT_WIDTH),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (core_out_valid),
        .in_ready  (core_out_ready),
        .in_data   (core_out_data),
        .out_valid (m_axis_valid),
        .out_ready (m_axis_ready),
        .out_data  (m_axis_data)
    );

    logic [IDX_BITS-1:0] out_idx;
    logic                out_pop;

    assign out_pop     = m_axis_valid && m_axis_ready;
    assign m_axis_last = (out_idx == LAST_IDX) && m_axis_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx       <= '0;
            out_frame_cnt <= '0;
        end else if (out_pop) begin
            if (m_axis_last) begin
                out_idx       <= '0;
                out_frame_cnt <= out_frame_cnt + 1'b1;
            end else begin
                out_idx <= out_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_stream_framer.sv
// Self-checking bench for fft_stream_framer: frame-check vector table plus directed sequences.
// Latency: n/a.
// Backpressure: exercised on core_in_ready and m_axis_ready.
module tb_fft_stream_framer;

    localparam int DW = 16;
    localparam int OW = 16;
    localparam int FL = 256;
    localparam int DEPTH = 16;
    localparam int CW = 16;

    logic            clk;
    logic            rst_n;
    logic            s_axis_valid;
    logic            s_axis_ready;
    logic [2*DW-1:0] s_axis_data;
    logic            s_axis_last;
    logic            core_in_valid;
    logic            core_in_ready;
    logic [2*DW-1:0] core_in_data;
    logic            core_out_valid;
    logic            core_out_ready;
    logic [2*OW-1:0] core_out_data;
    logic            m_axis_valid;
    logic            m_axis_ready;
    logic [2*OW-1:0] m_axis_data;
    logic            m_axis_last;
    logic            clear_err;
    logic            err_early_last;
    logic            err_missing_last;
    logic [CW-1:0]   in_frame_cnt;
    logic [CW-1:0]   out_frame_cnt;

    fft_stream_framer #(
        .DATA_WIDTH     (DW),
        .OUTPUT_WIDTH   (OW),
        .FRAME_LEN      (FL),
        .OUT_FIFO_DEPTH (DEPTH),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_valid     (s_axis_valid),
        .s_axis_ready     (s_axis_ready),
        .s_axis_data      (s_axis_data),
        .s_axis_last      (s_axis_last),
        .core_in_valid    (core_in_valid),
        .core_in_ready    (core_in_ready),
        .core_in_data     (core_in_data),
        .core_out_valid   (core_out_valid),
        .core_out_ready   (core_out_ready),
        .core_out_data    (core_out_data),
        .m_axis_valid     (m_axis_valid),
        .m_axis_ready     (m_axis_ready),
        .m_axis_data      (m_axis_data),
        .m_axis_last      (m_axis_last),
        .clear_err        (clear_err),
        .err_early_last   (err_early_last),
        .err_missing_last (err_missing_last),
        .in_frame_cnt     (in_frame_cnt),
        .out_frame_cnt    (out_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state, updated by the monitor at negedges.
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    int          pops_out = 0;
    int          last_cnt = 0;
    int          cyc = 0;
    int          first_acc = -1;
    int          first_vld = -1;
    logic [31:0] held_dat = '0;
    logic        held_last = 1'b0;
    logic        held_ok = 1'b0;
    int          seq = 0;
    int          oseq = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (core_in_valid && first_vld < 0) first_vld = cyc;
            if (core_in_valid && core_in_ready) begin
                if (in_q.size() == 0) chk("core_in_unexpected", 1, 0);
                else                  chk("core_in_data", core_in_data, in_q.pop_front());
            end
            if (s_axis_valid && s_axis_ready) begin
                in_q.push_back(s_axis_data);
                if (first_acc < 0) first_acc = cyc;
            end
            if (held_ok && m_axis_valid) begin
                chk("m_data_stable", m_axis_data, held_dat);
                chk("m_last_stable", m_axis_last, held_last);
            end
            held_ok   = m_axis_valid && !m_axis_ready;
            held_dat  = m_axis_data;
            held_last = m_axis_last;
            if (m_axis_valid && m_axis_ready) begin
                if (out_q.size() == 0) chk("m_unexpected", 1, 0);
                else                   chk("m_data", m_axis_data, out_q.pop_front());
                chk("m_last", m_axis_last, ((pops_out % FL) == FL - 1));
                if (m_axis_last) last_cnt++;
                pops_out++;
            end
            if (core_out_valid && core_out_ready) out_q.push_back(core_out_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        s_axis_valid   = 1'b0;
        s_axis_data    = '0;
        s_axis_last    = 1'b0;
        clear_err      = 1'b0;
        core_out_valid = 1'b0;
        core_out_data  = '0;
        core_in_ready  = 1'b1;
        m_axis_ready   = 1'b1;
        step();
        step();
        in_q.delete();
        out_q.delete();
        pops_out  = 0;
        last_cnt  = 0;
        held_ok   = 1'b0;
        first_acc = -1;
        first_vld = -1;
        rst_n     = 1'b1;
    endtask

    // Send n host samples; last is raised on sample last_at (-1: never).
    task automatic send(input int n, input int last_at, input bit clr_on_last);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int w;
            s_axis_valid = 1'b1;
            s_axis_data  = {seq[15:0], ~seq[15:0]};
            seq++;
            s_axis_last  = (i == last_at);
            clear_err    = clr_on_last && (i == last_at);
            acc = 1'b0;
            w = 0;
            while (!acc && w < 200) begin
                @(negedge clk);
                acc = s_axis_ready;
                step();
                w++;
            end
            if (!acc) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        clear_err    = 1'b0;
    endtask

    // Offer n core results, holding valid until each is taken.
    task automatic push_out(input int n);
        int p = 0;
        int w = 0;
        while (p < n && w < 5000) begin
            core_out_valid = 1'b1;
            core_out_data  = {oseq[15:0] ^ 16'hA5A5, oseq[15:0]};
            @(negedge clk);
            if (core_out_ready) begin
                p++;
                oseq++;
            end
            step();
            w++;
        end
        core_out_valid = 1'b0;
        if (p < n) chk("push_timeout", p, n);
    endtask

    typedef struct {
        int n;
        int last_at;
        bit do_clear;
        bit exp_early;
        bit exp_missing;
        int exp_cnt;
    } fvec_t;

    fvec_t tv[7];

    initial begin
        tv[0] = '{256, 255, 1'b0, 1'b0, 1'b0, 1};  // clean frame
        tv[1] = '{100,  99, 1'b1, 1'b1, 1'b0, 1};  // early last on #99
        tv[2] = '{256, 255, 1'b0, 1'b0, 1'b0, 2};  // resynchronised clean frame
        tv[3] = '{  1,   0, 1'b1, 1'b1, 1'b0, 2};  // last on the very first sample
        tv[4] = '{256,  -1, 1'b0, 1'b0, 1'b1, 3};  // missing last
        tv[5] = '{256, 255, 1'b1, 1'b0, 1'b1, 4};  // clean frame, missing flag still sticky
        tv[6] = '{255, 254, 1'b1, 1'b1, 1'b0, 4};  // last one sample too early

        do_reset();
        @(negedge clk);
        chk("rst_s_ready", s_axis_ready, 1);
        chk("rst_core_in_valid", core_in_valid, 0);
        chk("rst_core_in_data", core_in_data, 0);
        chk("rst_m_valid", m_axis_valid, 0);
        chk("rst_m_last", m_axis_last, 0);
        chk("rst_m_data", m_axis_data, 0);
        chk("rst_errs", {err_early_last, err_missing_last}, 0);
        chk("rst_cnts", {in_frame_cnt, out_frame_cnt}, 0);
        step();

        // ---- input frame checking, table driven ----
        for (int i = 0; i < 7; i++) begin
            send(tv[i].n, tv[i].last_at, 1'b0);
            chk($sformatf("v%0d_early", i), err_early_last, tv[i].exp_early);
            chk($sformatf("v%0d_missing", i), err_missing_last, tv[i].exp_missing);
            chk($sformatf("v%0d_in_cnt", i), in_frame_cnt, tv[i].exp_cnt);
            if (i == 0) chk("first_core_valid_lat", first_vld - first_acc, 1);
            if (tv[i].do_clear) begin
                clear_err = 1'b1;
                step();
                clear_err = 1'b0;
                chk($sformatf("v%0d_cleared", i), {err_early_last, err_missing_last}, 0);
            end
        end

        // ---- clear_err coinciding with an early-last event: set wins ----
        send(5, 4, 1'b1);
        chk("clr_vs_set_early", err_early_last, 1);
        chk("clr_vs_set_cnt", in_frame_cnt, 4);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("clr_after", err_early_last, 0);

        // ---- core_in backpressure: skid fills at 2, data held ----
        core_in_ready = 1'b0;
        send(2, -1, 1'b0);
        @(negedge clk);
        chk("skid_full_ready", s_axis_ready, 0);
        chk("skid_core_valid", core_in_valid, 1);
        chk("skid_head_data", core_in_data, in_q[0]);
        step();
        step();
        @(negedge clk);
        chk("skid_head_stable", core_in_data, in_q[0]);
        step();
        core_in_ready = 1'b1;
        send(254, 253, 1'b0);
        repeat (4) step();
        chk("skid_drained", in_q.size(), 0);
        chk("skid_in_cnt", in_frame_cnt, 5);
        chk("skid_errs", {err_early_last, err_missing_last}, 0);

        // ---- output FIFO fill with downstream stalled ----
        do_reset();
        m_axis_ready = 1'b0;
        begin
            int pushed = 0;
            for (int c = 0; c < 30; c++) begin
                core_out_valid = 1'b1;
                core_out_data  = {oseq[15:0] ^ 16'hA5A5, oseq[15:0]};
                @(negedge clk);
                if (c == 0) chk("m_valid_before_push", m_axis_valid, 0);
                if (c == 1) chk("m_valid_after_push", m_axis_valid, 1);
                if (core_out_ready) begin
                    pushed++;
                    oseq++;
                end
                step();
            end
            core_out_valid = 1'b0;
            chk("fifo_pushed_when_full", pushed, DEPTH);
            @(negedge clk);
            chk("fifo_full_ready", core_out_ready, 0);
            step();
            m_axis_ready = 1'b1;
            push_out(20 - pushed);
        end
        repeat (30) step();
        chk("fifo_drained", out_q.size(), 0);
        chk("fifo_pops", pops_out, 20);
        chk("fifo_no_last", last_cnt, 0);

        // ---- 512 results with downstream ready toggling ----
        do_reset();
        fork
            push_out(512);
            begin
                int w = 0;
                m_axis_ready = 1'b1;
                while (pops_out < 512 && w < 4000) begin
                    step();
                    m_axis_ready = ~m_axis_ready;
                    w++;
                end
                m_axis_ready = 1'b1;
            end
        join
        step();
        chk("tog_pops", pops_out, 512);
        chk("tog_last_cnt", last_cnt, 2);
        chk("tog_out_cnt", out_frame_cnt, 2);
        chk("tog_empty", m_axis_valid, 0);

        // ---- reset mid-frame with both buffers occupied ----
        do_reset();
        core_in_ready = 1'b0;
        m_axis_ready  = 1'b0;
        send(2, -1, 1'b0);
        push_out(3);
        @(negedge clk);
        chk("pre_rst_core_valid", core_in_valid, 1);
        chk("pre_rst_m_valid", m_axis_valid, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_core_valid", core_in_valid, 0);
        chk("async_rst_m_valid", m_axis_valid, 0);
        chk("async_rst_s_ready", s_axis_ready, 1);
        chk("async_rst_m_last", m_axis_last, 0);
        do_reset();
        send(256, 255, 1'b0);
        push_out(256);
        repeat (4) step();
        chk("post_rst_in_cnt", in_frame_cnt, 1);
        chk("post_rst_errs", {err_early_last, err_missing_last}, 0);
        chk("post_rst_in_drained", in_q.size(), 0);
        chk("post_rst_out_cnt", out_frame_cnt, 1);
        chk("post_rst_last_cnt", last_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
